pwm_switch_array: RTL and testbench
===================================

Name: pwm_switch_array

Overview:
- Parametrised successor to the single-channel photonic-switch PWM core.
- Drives CH switch channels from one shared prescaled timebase and a shared period counter.
- Each channel has its own set point A and reset point B, written through a valid/ready port.
- New values are double-buffered and take effect only at period boundaries, so a channel never glitches mid-period.

Parameters:
CH, 4, number of switch channels (>=1)
CW, 7, width of period counter, A/B set points and period
DIVW, 5, width of prescaler divide value
CHW, 2, width of channel index (>= clog2(CH), min 1)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
en  in  1  run enable
div  in  DIVW  prescaler: one tick every div+1 clk cycles
period  in  CW  counter wraps after reaching period (period+1 ticks per PWM cycle)
wr_valid  in  1  set-point write request
wr_ready  out  1  write slot free
wr_ch  in  CHW  target channel
wr_a  in  CW  new set point A
wr_b  in  CW  new reset point B
tick  out  1  one-cycle prescaler tick
cnt  out  CW  current period count
pwm  out  CH  switch drive levels
set_pulse  out  CH  one-cycle pulse when pwm[i] is set
rst_pulse  out  CH  one-cycle pulse when pwm[i] is cleared
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pcnt, cnt, tick, pwm, set_pulse, rst_pulse, busy = 0; every channel A=B=0; pending slot empty, so wr_ready=1; latched period=0.
- FSM states: IDLE, RUN, DRAIN (DRAIN only with the optional feature).
- IDLE->RUN: on the first clk edge with en=1. At that edge: latch period and div, pcnt=0, cnt=0.
- Prescaler (RUN/DRAIN): pcnt counts 0..div_latched. tick is registered and high for exactly one cycle at the edge where pcnt wraps to 0. div=0 gives a tick every cycle.
- Counter: on each tick, cnt increments. When cnt==period_latched, cnt wraps to 0 on the tick (boundary), and period/div are re-latched at that edge.
- Channel compare:
  - Evaluated on the cnt value loaded at a tick edge (cnt_next). pwm updates on the same edge as cnt.
  - cnt_next==A[i] and A!=B: pwm[i]<=1, set_pulse[i]=1 for the next cycle.
  - cnt_next==B[i]: pwm[i]<=0, rst_pulse[i]=1 for the next cycle.
  - A==B: reset wins; pwm stays 0; only rst_pulse fires.
  - A or B > period_latched: that event never occurs.
- Write handshake:
  - wr_ready = !pending.
  - Accept on wr_valid && wr_ready. Store {ch,a,b} in pending; wr_ready drops the next cycle.
  - wr_ch >= CH: accepted and silently discarded.
- Commit of pending to channel A/B:
  - In IDLE: the cycle after accept.
  - In RUN/DRAIN: at the boundary tick edge. The committed values are already used for the cnt_next=0 compare at that same edge.
  - pending clears on the commit edge, so wr_ready=1 the next cycle.
  - A write accepted on the same edge as a boundary commits at the following boundary.
- en=0 while in RUN (feature off): next edge goes to IDLE; cnt, pcnt, pwm cleared; no pulses generated; pending is kept and commits per the IDLE rule.
- Latency: cnt and pwm change 1 clk after the tick edge condition; pulses last 1 clk.

Optional Feature:
SAFE_STOP_EN
- Defined:
  - en=0 in RUN enters DRAIN. Counting and compares continue until the boundary, where state goes to IDLE and pwm is forced to 0 (rst_pulse fires for channels that were high).
  - en=1 again while in DRAIN returns to RUN with no disturbance to cnt.
  - busy stays high throughout DRAIN.
- Undefined: no DRAIN state; immediate stop as specified above.

Test Plan:
- Reset mid-run: release reset -> all outputs 0, wr_ready=1; assert reset with pwm=1 -> pwm=0 asynchronously.
- div=1, period=9, ch0 A=2 B=6, en=1 -> tick every 2 clk; pwm[0] high for 4 ticks (8 clk) per 20-clk cycle; set_pulse at cnt=2, rst_pulse at cnt=6.
- A=B=3 on ch1 -> pwm[1] never high; rst_pulse[1] once per period.
- While running, write ch0 A=0 B=5 mid-period -> old waveform until the wrap, new one from cnt=0 (pwm[0] rises on the wrap edge). Back-to-back wr_valid -> second write stalls with wr_ready=0 until commit.
- div=0, period=3, drop en at cnt=1 -> feature off: IDLE next cycle, pwm=0; feature on: runs to cnt=3, goes IDLE on the wrap, busy falls then.
- wr_ch=7 with CH=4 -> accepted; no channel changes.

Source files
------------

// File: rtl/pwm_switch_array.sv
// pwm_switch_array: drives CH photonic-switch channels from one shared
// prescaled timebase and one shared period counter. Each channel owns a
// set point A and a reset point B. New A/B values arrive through a
// single-entry valid/ready slot and only reach a channel at a period
// boundary, so a running waveform never glitches mid-period.
// Optional feature: define SAFE_STOP_EN to let a stop request drain to the
// end of the current period instead of stopping immediately.
module pwm_switch_array #(
  parameter int CH   = 4,
  parameter int CW   = 7,
  parameter int DIVW = 5,
  parameter int CHW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  input  logic [CW-1:0]   period,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [CW-1:0]   wr_a,
  input  logic [CW-1:0]   wr_b,
  output logic            tick,
  output logic [CW-1:0]   cnt,
  output logic [CH-1:0]   pwm,
  output logic [CH-1:0]   set_pulse,
  output logic [CH-1:0]   rst_pulse,
  output logic            busy
);

`ifdef SAFE_STOP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

  state_t state, state_next;

  logic [DIVW-1:0] pcnt;
  logic [DIVW-1:0] div_l;
  logic [CW-1:0]   period_l;

  logic [CW-1:0]   a_reg [CH];
  logic [CW-1:0]   b_reg [CH];

  logic            pend_valid;
  logic [CHW-1:0]  pend_ch;
  logic [CW-1:0]   pend_a;
  logic [CW-1:0]   pend_b;

  logic            running;
  logic            tick_cond;
  logic            boundary;
  logic            stop_abrupt;
  logic            stop_drain;
  logic            commit;
  logic            accept;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   a_eff [CH];
  logic [CW-1:0]   b_eff [CH];
  logic [CH-1:0]   set_hit;
  logic [CH-1:0]   rst_hit;
  logic [CH-1:0]   pwm_next;

  assign wr_ready = !pend_valid;
  assign busy     = (state != IDLE);

  // Timebase decode, commit timing and per-channel compares; a pending write
  // due at this boundary is folded in so the cnt=0 compare already uses it.
  always_comb begin
    running     = (state != IDLE);
    tick_cond   = running && (pcnt == div_l);
    boundary    = tick_cond && (cnt == period_l);
    cnt_next    = boundary ? '0 : cnt + CW'(1);
`ifdef SAFE_STOP_EN
    stop_abrupt = 1'b0;
    stop_drain  = running && !en && boundary;
`else
    stop_abrupt = running && !en;
    stop_drain  = 1'b0;
`endif
    accept      = wr_valid && !pend_valid;
    commit      = pend_valid && (!running || (boundary && !stop_abrupt));
    set_hit     = '0;
    rst_hit     = '0;
    pwm_next    = pwm;
    for (int i = 0; i < CH; i++) begin
      a_eff[i] = a_reg[i];
      b_eff[i] = b_reg[i];
      if (commit && (pend_ch == CHW'(i))) begin
        a_eff[i] = pend_a;
        b_eff[i] = pend_b;
      end
      rst_hit[i] = (cnt_next == b_eff[i]) && (b_eff[i] <= period_l);
      set_hit[i] = (cnt_next == a_eff[i]) && (a_eff[i] != b_eff[i]) &&
                   (a_eff[i] <= period_l);
      if (rst_hit[i])
        pwm_next[i] = 1'b0;
      else if (set_hit[i])
        pwm_next[i] = 1'b1;
    end
  end

  // Next-state decision: start on enable, stop either at once or at the
  // next period boundary depending on the build.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en) state_next = RUN;
`ifdef SAFE_STOP_EN
      RUN: if (!en) state_next = boundary ? IDLE : DRAIN;
      DRAIN: begin
        if (en)
          state_next = RUN;
        else if (boundary)
          state_next = IDLE;
      end
`else
      RUN: if (!en) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Prescaler, period counter and channel outputs; period/div are sampled
  // on start and again at every boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt      <= '0;
      div_l     <= '0;
      period_l  <= '0;
      cnt       <= '0;
      tick      <= 1'b0;
      pwm       <= '0;
      set_pulse <= '0;
      rst_pulse <= '0;
    end else begin
      tick      <= 1'b0;
      set_pulse <= '0;
      rst_pulse <= '0;
      if (!running) begin
        if (en) begin
          period_l <= period;
          div_l    <= div;
          pcnt     <= '0;
          cnt      <= '0;
        end
      end else if (stop_abrupt) begin
        pcnt <= '0;
        cnt  <= '0;
        pwm  <= '0;
      end else if (tick_cond) begin
        pcnt <= '0;
        tick <= 1'b1;
        cnt  <= cnt_next;
        if (boundary) begin
          period_l <= period;
          div_l    <= div;
        end
        if (stop_drain) begin
          pwm       <= '0;
          rst_pulse <= pwm;
        end else begin
          pwm       <= pwm_next;
          set_pulse <= set_hit;
          rst_pulse <= rst_hit;
        end
      end else begin
        pcnt <= pcnt + DIVW'(1);
      end
    end
  end

  // Single-entry write slot and the per-channel A/B registers it feeds;
  // an out-of-range channel index simply matches no channel on commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_a     <= '0;
      pend_b     <= '0;
      for (int i = 0; i < CH; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_ch    <= wr_ch;
        pend_a     <= wr_a;
        pend_b     <= wr_b;
      end
      if (commit) begin
        pend_valid <= 1'b0;
        for (int i = 0; i < CH; i++) begin
          if (pend_ch == CHW'(i)) begin
            a_reg[i] <= pend_a;
            b_reg[i] <= pend_b;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_switch_array.sv
// Testbench for pwm_switch_array (CH=4, CW=7, DIVW=5, CHW=3 so that an
// out-of-range channel index can be driven). Expected per-cycle outputs are
// queued when a run is started and popped each cycle as the DUT produces them.
module tb_pwm_switch_array;

  typedef struct packed {
    logic       tick;
    logic [6:0] cnt;
    logic [3:0] pwm;
    logic [3:0] sp;
    logic [3:0] rp;
    logic       busy;
    logic       rdy;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [4:0] div;
  logic [6:0] period;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_ch;
  logic [6:0] wr_a;
  logic [6:0] wr_b;
  logic       tick;
  logic [6:0] cnt;
  logic [3:0] pwm;
  logic [3:0] set_pulse;
  logic [3:0] rst_pulse;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  obs_t exp_q [$];

  pwm_switch_array #(.CH(4), .CW(7), .DIVW(5), .CHW(3)) dut (
    .clk(clk), .reset(reset), .en(en), .div(div), .period(period),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch),
    .wr_a(wr_a), .wr_b(wr_b), .tick(tick), .cnt(cnt), .pwm(pwm),
    .set_pulse(set_pulse), .rst_pulse(rst_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t sample_dut();
    obs_t o;
    o = {tick, cnt, pwm, set_pulse, rst_pulse, busy, wr_ready};
    return o;
  endfunction

  // Closed-form expectation n cycles after the start edge, with d = div+1.
  function automatic obs_t model_run(input int n, input int d, input int per,
                                     input logic [6:0] a [4], input logic [6:0] b [4],
                                     input logic rdy);
    obs_t o;
    int   c;
    logic tk;
    o  = '0;
    c  = (n / d) % (per + 1);
    tk = (n > 0) && (n % d == 0);
    o.tick = tk;
    o.cnt  = 7'(c);
    o.busy = 1'b1;
    o.rdy  = rdy;
    for (int i = 0; i < 4; i++) begin
      o.pwm[i] = (a[i] < b[i]) && (c >= a[i]) && (c < b[i]) &&
                 !(a[i] == 0 && n < (per + 1) * d);
      o.sp[i]  = tk && (c == a[i]) && (a[i] != b[i]) && (a[i] <= per);
      o.rp[i]  = tk && (c == b[i]) && (b[i] <= per);
    end
    return o;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [6:0] a,
                          input logic [6:0] b, output int waited);
    wr_valid = 1'b1; wr_ch = ch; wr_a = a; wr_b = b; waited = 0;
    while (!wr_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    e = '0; e.rdy = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    o = sample_dut(); e = exp_q.pop_front(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got=%h expected=%h", o, e);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    obs_t o, e;
    int w0, w1;
    logic [6:0] ta [4];
    logic [6:0] tb [4];
    pulse_reset();
    div = 5'd1; period = 7'd9;
    ta = '{7'd2, 7'd3, 7'd0, 7'd0};
    tb = '{7'd6, 7'd3, 7'd0, 7'd0};
    do_write(3'd0, 7'd2, 7'd6, w0);
    do_write(3'd1, 7'd3, 7'd3, w1);
    tests_run++;
    if (w0 >= 100 || w1 >= 100) begin
      tests_failed++;
      $display("[TB] FAIL basic_write_handshake waited=%0d/%0d limit=100", w0, w1);
    end
    @(negedge clk);
    en = 1'b1;
    for (int n = 0; n < 44; n++) exp_q.push_back(model_run(n, 2, 9, ta, tb, 1'b1));
    for (int n = 0; n < 44; n++) begin
      @(negedge clk);
      o = sample_dut(); e = exp_q.pop_front(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL basic n=%0d got tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b expected tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b",
                 n, o.tick, o.cnt, o.pwm, o.sp, o.rp, o.busy, o.rdy,
                 e.tick, e.cnt, e.pwm, e.sp, e.rp, e.busy, e.rdy);
      end
    end
  endtask

  task automatic test_update_back_to_back();
    obs_t o, e;
    int w0;
    logic rdy;
    logic [6:0] ta [4];
    logic [6:0] tb [4];
    pulse_reset();
    div = 5'd1; period = 7'd9;
    do_write(3'd0, 7'd2, 7'd6, w0);
    tests_run++;
    if (w0 >= 100) begin
      tests_failed++;
      $display("[TB] FAIL update_initial_write waited=%0d limit=100", w0);
    end
    @(negedge clk);
    en = 1'b1;
    for (int n = 0; n < 64; n++) begin
      ta = '{7'd2, 7'd0, 7'd0, 7'd0};
      tb = '{7'd6, 7'd0, 7'd0, 7'd0};
      if (n >= 20) begin ta[0] = 7'd0; tb[0] = 7'd5; end
      if (n >= 40) begin ta[2] = 7'd4; tb[2] = 7'd8; end
      rdy = !((n >= 9 && n <= 19) || (n >= 21 && n <= 39));
      exp_q.push_back(model_run(n, 2, 9, ta, tb, rdy));
    end
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      o = sample_dut(); e = exp_q.pop_front(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL update n=%0d got tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b expected tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b",
                 n, o.tick, o.cnt, o.pwm, o.sp, o.rp, o.busy, o.rdy,
                 e.tick, e.cnt, e.pwm, e.sp, e.rp, e.busy, e.rdy);
      end
      if (n == 8) begin
        wr_valid = 1'b1; wr_ch = 3'd0; wr_a = 7'd0; wr_b = 7'd5;
      end else if (n == 9) begin
        wr_ch = 3'd2; wr_a = 7'd4; wr_b = 7'd8;
      end else if (n == 21) begin
        wr_valid = 1'b0;
      end
    end
  endtask

  task automatic test_discard();
    obs_t o, e;
    int w0, w1;
    logic [6:0] ta [4];
    logic [6:0] tb [4];
    pulse_reset();
    div = 5'd0; period = 7'd3;
    ta = '{7'd1, 7'd0, 7'd0, 7'd0};
    tb = '{7'd2, 7'd0, 7'd0, 7'd0};
    do_write(3'd0, 7'd1, 7'd2, w0);
    do_write(3'd7, 7'd0, 7'd3, w1);
    tests_run++;
    if (w0 >= 100 || w1 >= 100) begin
      tests_failed++;
      $display("[TB] FAIL discard_write_handshake waited=%0d/%0d limit=100", w0, w1);
    end
    @(negedge clk);
    en = 1'b1;
    for (int n = 0; n < 12; n++) exp_q.push_back(model_run(n, 1, 3, ta, tb, 1'b1));
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      o = sample_dut(); e = exp_q.pop_front(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL discard n=%0d got tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b expected tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b",
                 n, o.tick, o.cnt, o.pwm, o.sp, o.rp, o.busy, o.rdy,
                 e.tick, e.cnt, e.pwm, e.sp, e.rp, e.busy, e.rdy);
      end
    end
  endtask

  task automatic test_stop();
    obs_t o, e, idle_e;
    int w0;
    logic [6:0] ta [4];
    logic [6:0] tb [4];
    pulse_reset();
    div = 5'd0; period = 7'd3;
    ta = '{7'd1, 7'd0, 7'd0, 7'd0};
    tb = '{7'd5, 7'd0, 7'd0, 7'd0};
    do_write(3'd0, 7'd1, 7'd5, w0);
    tests_run++;
    if (w0 >= 100) begin
      tests_failed++;
      $display("[TB] FAIL stop_write_handshake waited=%0d limit=100", w0);
    end
    @(negedge clk);
    en = 1'b1;
    idle_e = '0; idle_e.rdy = 1'b1;
    exp_q.push_back(model_run(0, 1, 3, ta, tb, 1'b1));
    exp_q.push_back(model_run(1, 1, 3, ta, tb, 1'b1));
`ifdef SAFE_STOP_EN
    exp_q.push_back(model_run(2, 1, 3, ta, tb, 1'b1));
    exp_q.push_back(model_run(3, 1, 3, ta, tb, 1'b1));
    e = idle_e; e.tick = 1'b1; e.rp = 4'b0001;
    exp_q.push_back(e);
    for (int n = 5; n < 8; n++) exp_q.push_back(idle_e);
`else
    for (int n = 2; n < 8; n++) exp_q.push_back(idle_e);
`endif
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      o = sample_dut(); e = exp_q.pop_front(); tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("[TB] FAIL stop n=%0d got tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b expected tick=%b cnt=%0d pwm=%b sp=%b rp=%b busy=%b rdy=%b",
                 n, o.tick, o.cnt, o.pwm, o.sp, o.rp, o.busy, o.rdy,
                 e.tick, e.cnt, e.pwm, e.sp, e.rp, e.busy, e.rdy);
      end
      if (n == 1) en = 1'b0;
    end
  endtask

  task automatic test_reset_async();
    obs_t o, e;
    int w0;
    pulse_reset();
    div = 5'd1; period = 7'd9;
    do_write(3'd0, 7'd2, 7'd6, w0);
    @(negedge clk);
    en = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (pwm[0] !== 1'b1 || w0 >= 100) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_precondition got pwm0=%b expected pwm0=1 (write wait %0d)", pwm[0], w0);
    end
    #2;
    reset = 1'b0;
    #1;
    e = '0; e.rdy = 1'b1;
    o = sample_dut(); tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got=%h expected=%h", o, e);
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; div = '0; period = '0;
    wr_valid = 1'b0; wr_ch = '0; wr_a = '0; wr_b = '0;
    test_reset();
    test_basic();
    test_update_back_to_back();
    test_discard();
    test_stop();
    test_reset_async();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
